// File: rtl/traffic_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : traffic_cmd_arbiter
// Description : Shares the traffic-light controller command bus between a
//               host port and a higher-priority service port. Each port has a
//               one-deep holding register. Timing data is range-checked, a
//               starvation guard limits back-to-back service grants, and a
//               fixed idle gap follows every issued command because the
//               controller bus has no ready.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_cmd_arbiter #(
  parameter int unsigned CMD_GAP    = 4,
  parameter int unsigned MIN_TIME   = 1,
  parameter int unsigned MAX_TIME   = 30000,
  parameter int unsigned FAIR_LIMIT = 2
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [2:0]  host_type_i,
  input  logic [15:0] host_data_i,
  input  logic        host_valid_i,
  output logic        host_ready_o,
  output logic        host_err_o,
  input  logic [2:0]  svc_type_i,
  input  logic [15:0] svc_data_i,
  input  logic        svc_valid_i,
  output logic        svc_ready_o,
  output logic        svc_err_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        cmd_valid_o,
  output logic        busy_o
);

  localparam int unsigned GAP_W  = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
  localparam int unsigned FAIR_W = $clog2(FAIR_LIMIT + 2);

  localparam logic [0:0]        c_ST_IDLE  = 1'b0;
  localparam logic [0:0]        c_ST_GAP   = 1'b1;
  localparam logic [GAP_W-1:0]  c_GAP_LAST = GAP_W'(CMD_GAP - 1);
  localparam logic [FAIR_W-1:0] c_FAIR_MAX = FAIR_W'(FAIR_LIMIT);
  localparam logic [15:0]       c_MIN_TIME = 16'(MIN_TIME);
  localparam logic [15:0]       c_MAX_TIME = 16'(MAX_TIME);

  // Holding registers
  logic              r_host_full;
  logic [2:0]        r_host_type;
  logic [15:0]       r_host_data;
  logic              r_svc_full;
  logic [2:0]        r_svc_type;
  logic [15:0]       r_svc_data;

  // Sequencing and arbitration state
  logic [0:0]        r_state;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [FAIR_W-1:0] r_fair_cnt;
  logic              r_lock;

  // Registered outputs
  logic              r_cmd_valid;
  logic [2:0]        r_cmd_type;
  logic [15:0]       r_cmd_data;
  logic              r_host_err;
  logic              r_svc_err;

  logic              w_grant;
  logic              w_pick_host;
  logic [2:0]        w_sel_type;
  logic [15:0]       w_sel_data;
  logic              w_legal;
  logic              w_issue;
  logic              w_host_load;
  logic              w_svc_load;

  // Service wins unless the host has already been passed over FAIR_LIMIT times.
  assign w_pick_host = r_host_full & (~r_svc_full | (r_fair_cnt == c_FAIR_MAX));
  assign w_grant     = (r_state == c_ST_IDLE) & (r_host_full | r_svc_full);
  assign w_sel_type  = w_pick_host ? r_host_type : r_svc_type;
  assign w_sel_data  = w_pick_host ? r_host_data : r_svc_data;
  assign w_issue     = w_grant & w_legal;

  assign w_host_load = host_valid_i & ~r_host_full;
  assign w_svc_load  = svc_valid_i  & ~r_svc_full;

  // Legality of the selected command: mode commands obey the lock, timing commands need in-range data.
  always_comb begin
    w_legal = 1'b0;
    case (w_sel_type)
      3'd0, 3'd1, 3'd2: w_legal = ~(w_pick_host & r_lock);
      3'd3, 3'd4, 3'd5: w_legal = (w_sel_data >= c_MIN_TIME) && (w_sel_data <= c_MAX_TIME);
      default:          w_legal = 1'b0;
    endcase
  end

  // Host holding register: loads on handshake, empties when the arbiter consumes it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_host_full <= 1'b0;
      r_host_type <= 3'd0;
      r_host_data <= 16'd0;
    end else if (w_host_load) begin
      r_host_full <= 1'b1;
      r_host_type <= host_type_i;
      r_host_data <= host_data_i;
    end else if (w_grant && w_pick_host) begin
      r_host_full <= 1'b0;
    end
  end

  // Service holding register: loads on handshake, empties when the arbiter consumes it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_svc_full <= 1'b0;
      r_svc_type <= 3'd0;
      r_svc_data <= 16'd0;
    end else if (w_svc_load) begin
      r_svc_full <= 1'b1;
      r_svc_type <= svc_type_i;
      r_svc_data <= svc_data_i;
    end else if (w_grant && !w_pick_host) begin
      r_svc_full <= 1'b0;
    end
  end

  // IDLE/GAP sequencer: an issued command forces CMD_GAP quiet cycles.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= c_ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_issue) begin
            r_state   <= c_ST_GAP;
            r_gap_cnt <= '0;
          end
        end
        c_ST_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state   <= c_ST_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state   <= c_ST_IDLE;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  // Command bus: single-cycle valid pulse, type/data hold their last value.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= 3'd0;
      r_cmd_data  <= 16'd0;
    end else begin
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd_type <= w_sel_type;
        r_cmd_data <= w_sel_data;
      end
    end
  end

  // Reject pulses, starvation counter and service lock bookkeeping.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_host_err <= 1'b0;
      r_svc_err  <= 1'b0;
      r_fair_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_host_err <= w_grant &  w_pick_host & ~w_legal;
      r_svc_err  <= w_grant & ~w_pick_host & ~w_legal;
      if (w_grant) begin
        if (w_pick_host) begin
          r_fair_cnt <= '0;
        end else if (r_host_full && (r_fair_cnt != c_FAIR_MAX)) begin
          r_fair_cnt <= r_fair_cnt + FAIR_W'(1);
        end
      end
      // Service "off" locks out host mode changes; service "run"/"blink" releases it.
      if (w_issue && !w_pick_host) begin
        if (w_sel_type == 3'd1) begin
          r_lock <= 1'b1;
        end else if ((w_sel_type == 3'd0) || (w_sel_type == 3'd2)) begin
          r_lock <= 1'b0;
        end
      end
    end
  end

  assign host_ready_o = ~r_host_full;
  assign svc_ready_o  = ~r_svc_full;
  assign host_err_o   = r_host_err;
  assign svc_err_o    = r_svc_err;
  assign cmd_valid_o  = r_cmd_valid;
  assign cmd_type_o   = r_cmd_type;
  assign cmd_data_o   = r_cmd_data;
  assign busy_o       = (r_state != c_ST_IDLE) | r_host_full | r_svc_full;

endmodule
`default_nettype wire

// File: tb/tb_traffic_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_cmd_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               behavioural model of traffic_cmd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_cmd_arbiter;

  localparam int CMD_GAP    = 4;
  localparam int MIN_TIME   = 1;
  localparam int MAX_TIME   = 30000;
  localparam int FAIR_LIMIT = 2;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [2:0]  host_type = '0;
  logic [15:0] host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_ready, host_err;
  logic [2:0]  svc_type = '0;
  logic [15:0] svc_data = '0;
  logic        svc_valid = 1'b0;
  logic        svc_ready, svc_err;
  logic [2:0]  cmd_type;
  logic [15:0] cmd_data;
  logic        cmd_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          log_cyc[$];
  logic [2:0]  log_type[$];
  logic [15:0] log_data[$];
  int          herr_cyc[$];
  int          serr_cyc[$];

  traffic_cmd_arbiter #(
    .CMD_GAP(CMD_GAP), .MIN_TIME(MIN_TIME), .MAX_TIME(MAX_TIME), .FAIR_LIMIT(FAIR_LIMIT)
  ) dut (
    .clk_i(clk), .arst_i(arst),
    .host_type_i(host_type), .host_data_i(host_data), .host_valid_i(host_valid),
    .host_ready_o(host_ready), .host_err_o(host_err),
    .svc_type_i(svc_type), .svc_data_i(svc_data), .svc_valid_i(svc_valid),
    .svc_ready_o(svc_ready), .svc_err_o(svc_err),
    .cmd_type_o(cmd_type), .cmd_data_o(cmd_data), .cmd_valid_o(cmd_valid),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Bus monitor: records every issued command and reject pulse with its edge number.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (cmd_valid === 1'b1) begin
      log_cyc.push_back(cyc);
      log_type.push_back(cmd_type);
      log_data.push_back(cmd_data);
    end
    if (host_err === 1'b1) herr_cyc.push_back(cyc);
    if (svc_err === 1'b1)  serr_cyc.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_cyc.delete(); log_type.delete(); log_data.delete();
    herr_cyc.delete(); serr_cyc.delete();
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    svc_valid  = 1'b0;
    arst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    clear_logs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for host ready, then presents one command for one edge.
  task automatic send_host(input logic [2:0] t, input logic [15:0] d, output int k);
    bit ok = 1'b0;
    k = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (host_ready === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL host_ready_wait: ready stayed %b, required 1", host_ready);
    end else begin
      host_type = t; host_data = d; host_valid = 1'b1;
      @(posedge clk); #1 k = cyc;
      @(negedge clk); host_valid = 1'b0;
    end
  endtask

  task automatic send_svc(input logic [2:0] t, input logic [15:0] d, output int k);
    bit ok = 1'b0;
    k = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (svc_ready === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL svc_ready_wait: ready stayed %b, required 1", svc_ready);
    end else begin
      svc_type = t; svc_data = d; svc_valid = 1'b1;
      @(posedge clk); #1 k = cyc;
      @(negedge clk); svc_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 7))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'd30000;
      3: return 16'd30001;
      4: return 16'hFFFF;
      default: return 16'($urandom_range(0, 40000));
    endcase
  endfunction

  // Spec rule: 6/7 never legal; 3..5 need data in range; 0..2 legal unless host is locked out.
  function automatic bit m_legal(input logic [2:0] t, input logic [15:0] d, input bit host_locked);
    if (t >= 3'd6) return 1'b0;
    if (t >= 3'd3) return (int'(d) >= MIN_TIME) && (int'(d) <= MAX_TIME);
    return !host_locked;
  endfunction

  task automatic test_reset();
    arst = 1'b1;
    host_valid = 1'b1; host_type = 3'd4; host_data = 16'd100;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %b required 0", cmd_valid); end
    n_checks++; if (cmd_type !== 3'd0) begin n_fail++; $display("FAIL rst_cmd_type: got %0d required 0", cmd_type); end
    n_checks++; if (cmd_data !== 16'd0) begin n_fail++; $display("FAIL rst_cmd_data: got %0d required 0", cmd_data); end
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rst_host_ready: got %b required 1", host_ready); end
    n_checks++; if (svc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_svc_ready: got %b required 1", svc_ready); end
    n_checks++; if (host_err !== 1'b0 || svc_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b%b required 00", host_err, svc_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    @(negedge clk);
    host_valid = 1'b0;
    arst = 1'b0;
    clear_logs();
  endtask

  task automatic test_basic_latency();
    int k;
    do_reset();
    send_host(3'd4, 16'd500, k);
    n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b required 0", host_ready); end
    idle(12);
    n_checks++;
    if (log_cyc.size() != 1) begin
      n_fail++; $display("FAIL basic_count: got %0d commands required 1", log_cyc.size());
    end else if (log_cyc[0] != k + 1 || log_type[0] != 3'd4 || log_data[0] != 16'd500) begin
      n_fail++; $display("FAIL basic_cmd: got edge %0d type %0d data %0d required edge %0d type 4 data 500",
                         log_cyc[0], log_type[0], log_data[0], k + 1);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    do_reset();
    @(negedge clk);
    svc_type = 3'd3; svc_data = 16'd100; svc_valid = 1'b1;
    host_type = 3'd5; host_data = 16'd200; host_valid = 1'b1;
    @(posedge clk); #1 k = cyc;
    @(negedge clk); svc_valid = 1'b0; host_valid = 1'b0;
    idle(15);
    n_checks++;
    if (log_cyc.size() != 2) begin
      n_fail++; $display("FAIL simul_count: got %0d commands required 2", log_cyc.size());
    end else begin
      if (log_cyc[0] != k + 1 || log_data[0] != 16'd100 || log_type[0] != 3'd3) begin
        n_fail++; $display("FAIL simul_first: got edge %0d data %0d required edge %0d data 100", log_cyc[0], log_data[0], k + 1);
      end
      n_checks++;
      if (log_cyc[1] != k + 1 + CMD_GAP + 1 || log_data[1] != 16'd200 || log_type[1] != 3'd5) begin
        n_fail++; $display("FAIL simul_second: got edge %0d data %0d required edge %0d data 200",
                           log_cyc[1], log_data[1], k + 2 + CMD_GAP);
      end
    end
  endtask

  task automatic test_fairness();
    int k, kb, kc;
    logic [15:0] exp_order [4];
    exp_order[0] = 16'd101; exp_order[1] = 16'd102; exp_order[2] = 16'd999; exp_order[3] = 16'd103;
    do_reset();
    @(negedge clk);
    svc_type = 3'd3; svc_data = 16'd101; svc_valid = 1'b1;
    host_type = 3'd4; host_data = 16'd999; host_valid = 1'b1;
    @(posedge clk); #1 k = cyc;
    @(negedge clk); svc_valid = 1'b0; host_valid = 1'b0;
    send_svc(3'd3, 16'd102, kb);
    send_svc(3'd3, 16'd103, kc);
    idle(25);
    n_checks++;
    if (log_cyc.size() != 4) begin
      n_fail++; $display("FAIL fair_count: got %0d commands required 4", log_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_data[i] != exp_order[i] || log_cyc[i] != k + 1 + i * (CMD_GAP + 1)) begin
          n_fail++; $display("FAIL fair_order[%0d]: got data %0d edge %0d required data %0d edge %0d",
                             i, log_data[i], log_cyc[i], exp_order[i], k + 1 + i * (CMD_GAP + 1));
        end
      end
    end
  endtask

  task automatic test_range_reject();
    int k1, k2, k3, k4, k5;
    do_reset();
    send_host(3'd3, 16'd0, k1);
    idle(4);
    send_host(3'd3, 16'd30001, k2);
    idle(4);
    n_checks++;
    if (herr_cyc.size() != 2) begin
      n_fail++; $display("FAIL range_err_count: got %0d pulses required 2", herr_cyc.size());
    end else if (herr_cyc[0] != k1 + 1 || herr_cyc[1] != k2 + 1) begin
      n_fail++; $display("FAIL range_err_edges: got %0d,%0d required %0d,%0d", herr_cyc[0], herr_cyc[1], k1 + 1, k2 + 1);
    end
    n_checks++; if (log_cyc.size() != 0) begin n_fail++; $display("FAIL range_no_cmd: got %0d commands required 0", log_cyc.size()); end
    send_svc(3'd7, 16'd10, k5);
    idle(4);
    n_checks++;
    if (serr_cyc.size() != 1 || serr_cyc[0] != k5 + 1) begin
      n_fail++; $display("FAIL svc_type7_err: got %0d pulses required 1 at edge %0d", serr_cyc.size(), k5 + 1);
    end
    send_host(3'd3, 16'd1, k3);
    idle(8);
    send_host(3'd5, 16'd30000, k4);
    idle(8);
    n_checks++;
    if (log_cyc.size() != 2) begin
      n_fail++; $display("FAIL range_bounds_count: got %0d commands required 2", log_cyc.size());
    end else if (log_data[0] != 16'd1 || log_data[1] != 16'd30000 || log_cyc[1] != k4 + 1) begin
      n_fail++; $display("FAIL range_bounds: got data %0d,%0d required 1,30000", log_data[0], log_data[1]);
    end
  endtask

  task automatic test_lock();
    int k;
    do_reset();
    send_svc(3'd1, 16'd0, k);
    idle(8);
    send_host(3'd0, 16'd7, k);
    idle(8);
    n_checks++;
    if (herr_cyc.size() != 1 || herr_cyc[0] != k + 1) begin
      n_fail++; $display("FAIL lock_host_reject: got %0d pulses required 1 at edge %0d", herr_cyc.size(), k + 1);
    end
    send_host(3'd4, 16'd50, k);
    idle(8);
    send_svc(3'd0, 16'd0, k);
    idle(8);
    send_host(3'd0, 16'd7, k);
    idle(8);
    n_checks++;
    if (log_cyc.size() != 4) begin
      n_fail++; $display("FAIL lock_count: got %0d commands required 4", log_cyc.size());
    end else if (log_type[0] != 3'd1 || log_type[1] != 3'd4 || log_data[1] != 16'd50 ||
                 log_type[2] != 3'd0 || log_type[3] != 3'd0 || log_data[3] != 16'd7 || log_cyc[3] != k + 1) begin
      n_fail++; $display("FAIL lock_seq: got types %0d,%0d,%0d,%0d last data %0d required 1,4,0,0 last data 7",
                         log_type[0], log_type[1], log_type[2], log_type[3], log_data[3]);
    end
    n_checks++; if (herr_cyc.size() != 1) begin n_fail++; $display("FAIL lock_err_total: got %0d required 1", herr_cyc.size()); end
  endtask

  task automatic test_reset_mid_gap();
    int k;
    do_reset();
    send_svc(3'd3, 16'd100, k);
    @(negedge clk);
    host_type = 3'd4; host_data = 16'd200; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    n_checks++; if (host_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_pre_reset: got ready %b busy %b required 0 1", host_ready, busy); end
    #2 arst = 1'b1;
    #1;
    n_checks++; if (cmd_valid !== 1'b0 || cmd_type !== 3'd0 || cmd_data !== 16'd0) begin
      n_fail++; $display("FAIL gap_rst_cmd: got valid %b type %0d data %0d required 0 0 0", cmd_valid, cmd_type, cmd_data);
    end
    n_checks++; if (host_ready !== 1'b1 || svc_ready !== 1'b1) begin
      n_fail++; $display("FAIL gap_rst_ready: got %b%b required 11", host_ready, svc_ready);
    end
    n_checks++; if (busy !== 1'b0 || host_err !== 1'b0 || svc_err !== 1'b0) begin
      n_fail++; $display("FAIL gap_rst_busy_err: got busy %b err %b%b required 0 00", busy, host_err, svc_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    clear_logs();
    idle(20);
    n_checks++; if (log_cyc.size() != 0) begin n_fail++; $display("FAIL gap_rst_discard: got %0d commands required 0", log_cyc.size()); end
  endtask

  task automatic test_random();
    bit          m_hfull = 0, m_sfull = 0, m_lock = 0;
    logic [2:0]  m_ht = '0, m_st = '0;
    logic [15:0] m_hd = '0, m_sd = '0;
    int          m_cool = 0, m_fair = 0;
    bit          h_acc = 1, s_acc = 1;
    bit          e_valid, e_herr, e_serr, use_host, ok;
    logic [2:0]  e_type, t;
    logic [15:0] e_data, d;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (!host_valid || h_acc) begin
        host_valid = ($urandom_range(0, 2) == 0);
        host_type  = 3'($urandom_range(0, 7));
        host_data  = pick_data();
      end
      if (!svc_valid || s_acc) begin
        svc_valid = ($urandom_range(0, 3) == 0);
        svc_type  = 3'($urandom_range(0, 7));
        svc_data  = pick_data();
      end
      @(posedge clk);
      h_acc = host_valid && !m_hfull;
      s_acc = svc_valid && !m_sfull;
      e_valid = 0; e_herr = 0; e_serr = 0; e_type = '0; e_data = '0;
      if (m_cool == 0 && (m_hfull || m_sfull)) begin
        use_host = m_hfull && (!m_sfull || m_fair == FAIR_LIMIT);
        t  = use_host ? m_ht : m_st;
        d  = use_host ? m_hd : m_sd;
        ok = m_legal(t, d, use_host && m_lock);
        if (use_host) begin
          m_hfull = 0; m_fair = 0;
        end else begin
          m_sfull = 0;
          if (m_hfull && m_fair < FAIR_LIMIT) m_fair++;
        end
        if (ok) begin
          e_valid = 1; e_type = t; e_data = d; m_cool = CMD_GAP;
          if (!use_host && t == 3'd1) m_lock = 1;
          if (!use_host && (t == 3'd0 || t == 3'd2)) m_lock = 0;
        end else if (use_host) begin
          e_herr = 1;
        end else begin
          e_serr = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end
      if (h_acc) begin m_hfull = 1; m_ht = host_type; m_hd = host_data; end
      if (s_acc) begin m_sfull = 1; m_st = svc_type; m_sd = svc_data; end
      #1;
      n_checks++;
      if (cmd_valid !== e_valid || (e_valid && (cmd_type !== e_type || cmd_data !== e_data))) begin
        n_fail++; $display("FAIL rand_cmd @%0d: got v%b t%0d d%0d required v%b t%0d d%0d",
                           cyc, cmd_valid, cmd_type, cmd_data, e_valid, e_type, e_data);
      end
      n_checks++;
      if (host_err !== e_herr || svc_err !== e_serr) begin
        n_fail++; $display("FAIL rand_err @%0d: got %b%b required %b%b", cyc, host_err, svc_err, e_herr, e_serr);
      end
      n_checks++;
      if (host_ready !== !m_hfull || svc_ready !== !m_sfull || busy !== (m_cool > 0 || m_hfull || m_sfull)) begin
        n_fail++; $display("FAIL rand_status @%0d: got rdy %b%b busy %b required rdy %b%b busy %b", cyc,
                           host_ready, svc_ready, busy, !m_hfull, !m_sfull, (m_cool > 0 || m_hfull || m_sfull));
      end
    end
    host_valid = 1'b0;
    svc_valid  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_simultaneous();
    test_fairness();
    test_range_reject();
    test_lock();
    test_reset_mid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
